// File: rtl/l2_line_mem_responder_if.sv
// l2_line_mem_responder_if: L2-to-memory line request/response bundle
//   master: L2 controller (drives requests, receives ready/line)
//   slave : memory responder (receives requests, drives ready/line)
interface l2_line_mem_responder_if #(
    parameter int TNUM3      = 18,
    parameter int INUM3      = 8,
    parameter int LINE_WIDTH = 512
);
    logic                  read_L2_MEM;
    logic                  write_L2_MEM;
    logic [TNUM3-1:0]      tag_L2_MEM;
    logic [INUM3-1:0]      index_L2_MEM;
    logic [TNUM3-1:0]      write_tag_L2_MEM;
    logic [LINE_WIDTH-1:0] write_data_L2_MEM;
    logic                  ready_MEM_L2;
    logic [LINE_WIDTH-1:0] read_data_MEM_L2;
    modport master(
        output read_L2_MEM, write_L2_MEM, tag_L2_MEM, index_L2_MEM, write_tag_L2_MEM, write_data_L2_MEM,
        input  ready_MEM_L2, read_data_MEM_L2
    );
    modport slave(
        input  read_L2_MEM, write_L2_MEM, tag_L2_MEM, index_L2_MEM, write_tag_L2_MEM, write_data_L2_MEM,
        output ready_MEM_L2, read_data_MEM_L2
    );
endinterface

// File: rtl/l2_line_mem_responder.sv
// l2_line_mem_responder: serialises L2 line fills/write-backs onto a word-wide single-port BRAM
//   clk, rst          : clock, synchronous active-high reset
//   l2 (slave)        : line request bundle; ready_MEM_L2 pulses once per transaction
//   ram_en/we/addr/din: registered BRAM command; ram_dout returns RD_LAT cycles after a read
//   L2MEM_PERF_CNT_EN : when defined, adds rd_line_cnt_o / wr_line_cnt_o line counters
module l2_line_mem_responder #(
    parameter int RAM_WIDTH  = 32,
    parameter int LINE_WIDTH = 512,
    parameter int TNUM3      = 18,
    parameter int INUM3      = 8,
    parameter int ADDR_W     = 22,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_line_mem_responder_if.slave l2,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [RAM_WIDTH-1:0]  ram_din,
`ifdef L2MEM_PERF_CNT_EN
    output logic [31:0]           rd_line_cnt_o,
    output logic [31:0]           wr_line_cnt_o,
`endif
    input  logic [RAM_WIDTH-1:0]  ram_dout
);
    localparam int WORDS = LINE_WIDTH / RAM_WIDTH;
    localparam int BW    = $clog2(WORDS);
    localparam int AW    = TNUM3 + INUM3 + BW;
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_DRAIN, RESP, WAIT_DROP} state_t;
    state_t                          r_state;
    logic [BW-1:0]                   r_beat;
    logic [TNUM3-1:0]                r_tag;
    logic [TNUM3-1:0]                r_wtag;
    logic [INUM3-1:0]                r_idx;
    logic                            r_rd;
`ifdef L2MEM_PERF_CNT_EN
    logic                            r_wr;
`endif
    logic [WORDS-1:0][RAM_WIDTH-1:0] r_wdata;
    logic [WORDS-1:0][RAM_WIDTH-1:0] r_line;
    logic [WORDS-1:0][RAM_WIDTH-1:0] w_line;
    logic [RD_LAT-1:0]               r_vld;
    logic [BW-1:0]                   r_vbeat [RD_LAT];
    logic [BW-1:0]                   w_nbeat;
    assign w_nbeat = r_beat + 1'b1;
    function automatic logic [ADDR_W-1:0] f_addr(input logic [TNUM3-1:0] t, input logic [INUM3-1:0] i, input logic [BW-1:0] b);
        logic [AW-1:0] full;
        full = {t, i, b};
        return full[ADDR_W-1:0];
    endfunction
    // Line being assembled including the word arriving this cycle, so RESP can publish it on entry
    always_comb begin
        w_line = r_line;
        if (r_vld[RD_LAT-1]) w_line[r_vbeat[RD_LAT-1]] = ram_dout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= IDLE;
            r_beat              <= '0;
            r_line              <= '0;
            r_vld               <= '0;
            ram_en              <= 1'b0;
            ram_we              <= 1'b0;
            ram_addr            <= '0;
            ram_din             <= '0;
            l2.ready_MEM_L2     <= 1'b0;
            l2.read_data_MEM_L2 <= '0;
`ifdef L2MEM_PERF_CNT_EN
            rd_line_cnt_o       <= '0;
            wr_line_cnt_o       <= '0;
`endif
        end else begin
            r_line          <= w_line;
            // Beat tag travels with the read so the capture slot is known when data returns
            r_vld[0]        <= ram_en & ~ram_we;
            r_vbeat[0]      <= r_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_vbeat[i] <= r_vbeat[i-1];
            end
            l2.ready_MEM_L2 <= 1'b0;
            case (r_state)
                IDLE: if (l2.read_L2_MEM | l2.write_L2_MEM) begin
                    r_tag    <= l2.tag_L2_MEM;
                    r_wtag   <= l2.write_tag_L2_MEM;
                    r_idx    <= l2.index_L2_MEM;
                    r_wdata  <= l2.write_data_L2_MEM;
                    r_rd     <= l2.read_L2_MEM;
`ifdef L2MEM_PERF_CNT_EN
                    r_wr     <= l2.write_L2_MEM;
`endif
                    r_beat   <= '0;
                    ram_en   <= 1'b1;
                    ram_we   <= l2.write_L2_MEM;
                    ram_addr <= f_addr(l2.write_L2_MEM ? l2.write_tag_L2_MEM : l2.tag_L2_MEM, l2.index_L2_MEM, '0);
                    ram_din  <= l2.write_data_L2_MEM[RAM_WIDTH-1:0];
                    r_state  <= l2.write_L2_MEM ? WR : RD_ISSUE;
                end
                WR: if (r_beat != BW'(WORDS-1)) begin
                    r_beat   <= w_nbeat;
                    ram_addr <= f_addr(r_wtag, r_idx, w_nbeat);
                    ram_din  <= r_wdata[w_nbeat];
                end else begin
                    r_beat          <= '0;
                    ram_we          <= 1'b0;
                    ram_en          <= r_rd;
                    ram_addr        <= r_rd ? f_addr(r_tag, r_idx, '0) : '0;
                    ram_din         <= '0;
                    l2.ready_MEM_L2 <= ~r_rd;
                    r_state         <= r_rd ? RD_ISSUE : RESP;
                end
                RD_ISSUE: if (r_beat != BW'(WORDS-1)) begin
                    r_beat   <= w_nbeat;
                    ram_addr <= f_addr(r_tag, r_idx, w_nbeat);
                end else begin
                    r_beat   <= '0;
                    ram_en   <= 1'b0;
                    ram_addr <= '0;
                    r_state  <= RD_DRAIN;
                end
                // r_beat doubles as the drain counter; the last word lands on the final drain cycle
                RD_DRAIN: if (r_beat == BW'(RD_LAT-1)) begin
                    r_beat              <= '0;
                    l2.ready_MEM_L2     <= 1'b1;
                    l2.read_data_MEM_L2 <= w_line;
                    r_state             <= RESP;
                end else begin
                    r_beat <= w_nbeat;
                end
                RESP: begin
`ifdef L2MEM_PERF_CNT_EN
                    rd_line_cnt_o <= rd_line_cnt_o + 32'(r_rd);
                    wr_line_cnt_o <= wr_line_cnt_o + 32'(r_wr);
`endif
                    r_state <= WAIT_DROP;
                end
                WAIT_DROP: if (!l2.read_L2_MEM && !l2.write_L2_MEM) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
